// File: rtl/arbitro_memoria.sv
// arbitro_memoria: fixed-priority arbiter sharing one multi-bank board memory between
// the validator (single accesses and full-bank scans), the collider and the display.
module arbitro_memoria #(
    parameter int NBANK = 2,
    parameter int DW    = 64,
    parameter int AW    = 5,
    parameter int RDLAT = 1,
    parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                clk,
    input  logic                resetGeral,
    input  logic                val_req,
    input  logic                val_burst,
    input  logic                val_we,
    input  logic [BW-1:0]       val_bank,
    input  logic [AW-1:0]       val_addr,
    input  logic [DW-1:0]       val_wdata,
    output logic                val_gnt,
    output logic                val_rvalid,
    output logic [DW-1:0]       val_rdata,
    output logic [AW-1:0]       val_raddr,
    output logic                val_done,
    input  logic                col_req,
    input  logic                col_we,
    input  logic [BW-1:0]       col_bank,
    input  logic [AW-1:0]       col_addr,
    input  logic [DW-1:0]       col_wdata,
    output logic                col_gnt,
    output logic                col_rvalid,
    output logic [DW-1:0]       col_rdata,
    input  logic [BW-1:0]       vga_bank,
    input  logic [AW-1:0]       vga_addr,
    output logic                vga_rvalid,
    output logic [DW-1:0]       vga_rdata,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    output logic [NBANK-1:0]    mem_we,
    input  logic [NBANK*DW-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, VGA, VAL, VAL_SCAN, COL} state_t;
    typedef struct packed {
        logic          vld;
        logic [1:0]    own;
        logic [BW-1:0] bank;
        logic [AW-1:0] raddr;
        logic          last;
    } tag_t;
    localparam logic [1:0] OWN_VGA = 2'd0, OWN_VAL = 2'd1, OWN_COL = 2'd2;

    state_t        state, pick;
    logic [AW-1:0] cnt;
    logic          op_vld, op_we, op_last, in_range;
    logic [1:0]    op_own;
    logic [BW-1:0] op_bank;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_wdata, rd;
    tag_t          iss, t;
    tag_t          pipe [RDLAT];

    // the access placed on the memory bus at the next edge, decided by the current owner
    always_comb begin
        op_vld   = 1'b0;
        op_we    = 1'b0;
        op_last  = 1'b0;
        op_own   = OWN_VGA;
        op_bank  = vga_bank;
        op_addr  = vga_addr;
        op_wdata = val_wdata;
        case (state)
            VGA: op_vld = 1'b1;
            VAL: begin
                op_vld  = val_req;
                op_we   = val_we;
                op_own  = OWN_VAL;
                op_bank = val_bank;
                op_addr = val_addr;
            end
            VAL_SCAN: begin
                op_vld  = val_req;
                op_own  = OWN_VAL;
                op_bank = val_bank;
                op_addr = cnt;
                op_last = &cnt;
            end
            COL: begin
                op_vld   = col_req;
                op_we    = col_we;
                op_own   = OWN_COL;
                op_bank  = col_bank;
                op_addr  = col_addr;
                op_wdata = col_wdata;
            end
            default: op_vld = 1'b0;
        endcase
    end

    assign in_range = int'(op_bank) < NBANK;
    assign pick     = val_req ? (val_burst ? VAL_SCAN : VAL) : col_req ? COL : VGA;

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            state     <= IDLE;
            cnt       <= '0;
            val_gnt   <= 1'b0;
            col_gnt   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
            iss       <= '0;
            for (int i = 0; i < RDLAT; i++) pipe[i] <= '0;
        end else begin
            case (state)
                IDLE, VGA: state <= pick;
                VAL:       state <= val_req ? VAL : VGA;
                VAL_SCAN:  state <= (val_req && !(&cnt)) ? VAL_SCAN : VGA;
                COL:       state <= col_req ? COL : VGA;
                default:   state <= IDLE;
            endcase
            cnt     <= (state == VAL_SCAN && val_req && !(&cnt)) ? cnt + 1'b1 : '0;
            val_gnt <= op_vld && op_own == OWN_VAL;
            col_gnt <= op_vld && op_own == OWN_COL;
            mem_we  <= (op_vld && op_we && in_range) ? NBANK'(1) << op_bank : '0;
            if (op_vld) mem_addr <= op_addr;
            if (op_vld && op_we) mem_wdata <= op_wdata;
            iss     <= '{vld: op_vld && !op_we, own: op_own, bank: op_bank, raddr: op_addr, last: op_last};
            pipe[0] <= iss;
            for (int i = 1; i < RDLAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign t = pipe[RDLAT-1];

    // out-of-range banks match no slice and read back as zero
    always_comb begin
        rd = '0;
        for (int k = 0; k < NBANK; k++)
            if (t.bank == BW'(k)) rd = mem_rdata[k*DW +: DW];
    end

    assign val_rvalid = t.vld && t.own == OWN_VAL;
    assign col_rvalid = t.vld && t.own == OWN_COL;
    assign vga_rvalid = t.vld && t.own == OWN_VGA;
    assign val_rdata  = val_rvalid ? rd : '0;
    assign col_rdata  = col_rvalid ? rd : '0;
    assign vga_rdata  = vga_rvalid ? rd : '0;
    assign val_raddr  = val_rvalid ? t.raddr : '0;
    assign val_done   = val_rvalid && t.last;
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: random and directed traffic on all three ports, checked every cycle
// against a transaction-level model with its own shadow copy of the board memory.
module tb_arbitro_memoria;
    localparam int NB = 3, DW = 64, AW = 5, RL = 3, BW = 2, NW = 2**AW;
    localparam int O_IDLE = 0, O_VGA = 1, O_VAL = 2, O_SCAN = 3, O_COL = 4;

    logic clk = 1'b0, resetGeral = 1'b0;
    logic val_req = 1'b0, val_burst = 1'b0, val_we = 1'b0;
    logic [BW-1:0] val_bank = '0, col_bank = '0, vga_bank = '0;
    logic [AW-1:0] val_addr = '0, col_addr = '0, vga_addr = '0;
    logic [DW-1:0] val_wdata = '0, col_wdata = '0;
    logic col_req = 1'b0, col_we = 1'b0;
    logic val_gnt, val_rvalid, val_done, col_gnt, col_rvalid, vga_rvalid;
    logic [DW-1:0] val_rdata, col_rdata, vga_rdata, mem_wdata;
    logic [AW-1:0] val_raddr, mem_addr;
    logic [NB-1:0] mem_we;
    logic [NB*DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    arbitro_memoria #(.NBANK(NB), .DW(DW), .AW(AW), .RDLAT(RL)) dut (
        .clk(clk), .resetGeral(resetGeral),
        .val_req(val_req), .val_burst(val_burst), .val_we(val_we), .val_bank(val_bank),
        .val_addr(val_addr), .val_wdata(val_wdata), .val_gnt(val_gnt), .val_rvalid(val_rvalid),
        .val_rdata(val_rdata), .val_raddr(val_raddr), .val_done(val_done),
        .col_req(col_req), .col_we(col_we), .col_bank(col_bank), .col_addr(col_addr),
        .col_wdata(col_wdata), .col_gnt(col_gnt), .col_rvalid(col_rvalid), .col_rdata(col_rdata),
        .vga_bank(vga_bank), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(int k, int a);
        return 64'h9E3779B97F4A7C15 * 64'(k * NW + a + 1);
    endfunction

    // board memory: RL-cycle read latency, data snapshotted when the address is taken
    logic [DW-1:0] mem [NB][NW];
    logic [NB*DW-1:0] rq [RL];
    bit loaded = 1'b0;
    assign mem_rdata = rq[RL-1];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < NB; k++)
                for (int a = 0; a < NW; a++) mem[k][a] <= init_word(k, a);
            loaded <= 1'b1;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (mem_we[k]) mem[k][mem_addr] <= mem_wdata;
                rq[0][k*DW +: DW] <= mem[k][mem_addr];
            end
            for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
        end
    end

    typedef struct {
        int due;
        int port;
        logic [DW-1:0] data;
        int raddr;
        bit last;
    } resp_t;

    resp_t pend[$];
    logic [DW-1:0] sh [NB][NW];
    int own = O_IDLE, idx = 0, cyc = 0, checks = 0, errors = 0;
    bit pw_v = 1'b0;
    int pw_b, pw_a;
    logic [DW-1:0] pw_d, e_wd = '0;
    bit e_act = 1'b0, e_wr = 1'b0, e_vg = 1'b0, e_cg = 1'b0;
    logic [NB-1:0] e_we = '0;
    logic [AW-1:0] e_addr = '0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one clock edge of the reference: who owns the bus, what access it makes, who owns next
    task automatic model_step();
        bit act, wr, last;
        int b, a, port;
        logic [DW-1:0] d;
        resp_t r;
        cyc++;
        if (pw_v) sh[pw_b][pw_a] = pw_d;
        pw_v = 1'b0;
        act = 1'b1; wr = 1'b0; last = 1'b0; d = '0;
        b = int'(vga_bank); a = int'(vga_addr);
        case (own)
            O_IDLE: act = 1'b0;
            O_VAL: begin act = val_req; wr = val_we; b = int'(val_bank); a = int'(val_addr); d = val_wdata; end
            O_SCAN: begin act = val_req; b = int'(val_bank); a = idx; last = (idx == NW - 1); end
            O_COL: begin act = col_req; wr = col_we; b = int'(col_bank); a = int'(col_addr); d = col_wdata; end
            default: ;
        endcase
        port = (own == O_SCAN) ? O_VAL : own;
        e_act = act;
        e_wr = act && wr;
        e_vg = act && port == O_VAL;
        e_cg = act && port == O_COL;
        e_we = (e_wr && b < NB) ? NB'(1) << b : '0;
        if (act) e_addr = AW'(a);
        if (e_wr) e_wd = d;
        if (e_wr && b < NB) begin pw_v = 1'b1; pw_b = b; pw_a = a; pw_d = d; end
        if (act && !wr) begin
            r.due = cyc + RL; r.port = port; r.raddr = a; r.last = last; r.data = '0;
            if (b < NB) r.data = sh[b][a];
            pend.push_back(r);
        end
        case (own)
            O_IDLE, O_VGA: own = val_req ? (val_burst ? O_SCAN : O_VAL) : col_req ? O_COL : O_VGA;
            O_VAL: own = val_req ? O_VAL : O_VGA;
            O_SCAN: begin own = (val_req && !last) ? O_SCAN : O_VGA; idx = (own == O_SCAN) ? idx + 1 : 0; end
            default: own = col_req ? O_COL : O_VGA;
        endcase
    endtask

    task automatic compare();
        bit rv, rc, rg;
        resp_t r;
        rv = 1'b0; rc = 1'b0; rg = 1'b0;
        r.last = 1'b0; r.data = '0; r.raddr = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            rv = r.port == O_VAL; rc = r.port == O_COL; rg = r.port == O_VGA;
        end
        chk("val_gnt", val_gnt, e_vg);
        chk("col_gnt", col_gnt, e_cg);
        chk("mem_we", mem_we, e_we);
        if (e_act) chk("mem_addr", mem_addr, e_addr);
        if (e_wr) chk("mem_wdata", mem_wdata, e_wd);
        chk("val_rvalid", val_rvalid, rv);
        chk("col_rvalid", col_rvalid, rc);
        chk("vga_rvalid", vga_rvalid, rg);
        chk("val_done", val_done, rv && r.last);
        if (rv) begin chk("val_rdata", val_rdata, r.data); chk("val_raddr", val_raddr, r.raddr); end
        if (rc) chk("col_rdata", col_rdata, r.data);
        if (rg) chk("vga_rdata", vga_rdata, r.data);
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetGeral) model_step();
        #1 compare();
    endtask

    task automatic do_reset(int n);
        resetGeral = 1'b0;
        #1;
        chk("rst_flags", {val_gnt, col_gnt, val_rvalid, col_rvalid, vga_rvalid, val_done, mem_we}, '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_rdata", val_rdata | col_rdata | vga_rdata, '0);
        chk("rst_raddr", val_raddr, '0);
        own = O_IDLE; idx = 0; pend.delete(); pw_v = 1'b0;
        e_act = 1'b0; e_wr = 1'b0; e_vg = 1'b0; e_cg = 1'b0; e_we = '0;
        repeat (n) tick();
        @(negedge clk) resetGeral = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, first_issue, first_rv, nrv, ndone;
        for (int k = 0; k < NB; k++)
            for (int a = 0; a < NW; a++) sh[k][a] = init_word(k, a);
        do_reset(3);
        // full scan of bank 1; val_we must be ignored during the scan
        val_req = 1'b1; val_burst = 1'b1; val_bank = 2'd1; val_we = 1'b1; val_addr = 5'd17;
        first_issue = -1; first_rv = -1; nrv = 0; ndone = 0;
        tick();
        chk("first_gnt_late", val_gnt, 1'b0);
        for (int i = 0; i < NW + RL + 10 && ndone == 0; i++) begin
            tick();
            if (val_gnt && first_issue < 0) first_issue = cyc;
            if (val_rvalid) begin
                if (first_rv < 0) first_rv = cyc;
                nrv++;
                if (val_done) begin ndone++; chk("scan_done_raddr", val_raddr, NW - 1); end
            end
        end
        chk("scan_count", nrv, NW);
        chk("scan_done", ndone, 1);
        chk("scan_latency", first_rv - first_issue, RL);
        val_req = 1'b0; val_burst = 1'b0; val_we = 1'b0;
        repeat (RL + 4) tick();
        // contention: validator wins, collider follows within the bound
        val_req = 1'b1; col_req = 1'b1; val_addr = 5'd3; col_bank = 2'd2; col_addr = 5'd9;
        repeat (6) begin tick(); chk("cont_col_low", col_gnt, 1'b0); end
        val_req = 1'b0;
        w = 0;
        while (!col_gnt && w < NW + RL + 2) begin tick(); w++; end
        chk("col_wait_bound", col_gnt, 1'b1);
        col_req = 1'b0;
        repeat (RL + 4) tick();
        // single collider write, then read it back through the display port
        col_req = 1'b1; col_we = 1'b1; col_bank = 2'd0; col_addr = 5'd7; col_wdata = 64'hA5;
        w = 0;
        while (!col_gnt && w < 8) begin tick(); w++; end
        chk("wr_gnt", col_gnt, 1'b1);
        chk("wr_mem_we", mem_we, 3'b001);
        chk("wr_mem_addr", mem_addr, 7);
        col_req = 1'b0; col_we = 1'b0;
        tick();
        chk("wr_one_cycle", mem_we, '0);
        vga_bank = 2'd0; vga_addr = 5'd7;
        repeat (RL + 2) tick();
        w = 0;
        while (!vga_rvalid && w < 8) begin tick(); w++; end
        chk("vga_rvalid", vga_rvalid, 1'b1);
        chk("vga_readback", vga_rdata, 64'hA5);
        // out-of-range bank: write suppressed, read answers zero
        col_req = 1'b1; col_we = 1'b1; col_bank = 2'd3; col_addr = 5'd5; col_wdata = 64'h1234;
        w = 0;
        while (!col_gnt && w < 8) begin tick(); w++; end
        chk("oor_mem_we", mem_we, '0);
        col_we = 1'b0;
        tick();
        col_req = 1'b0;
        w = 0;
        while (!col_rvalid && w < 8) begin tick(); w++; end
        chk("oor_rvalid", col_rvalid, 1'b1);
        chk("oor_rdata", col_rdata, '0);
        repeat (RL + 4) tick();
        // abort a scan at address 10
        val_req = 1'b1; val_burst = 1'b1; val_bank = 2'd2;
        w = 0;
        while (!(val_gnt && mem_addr == 5'd10) && w < 40) begin tick(); w++; end
        chk("abort_at10", mem_addr, 10);
        val_req = 1'b0; val_burst = 1'b0;
        ndone = 0;
        repeat (RL + 4) begin tick(); if (val_done) ndone++; end
        chk("abort_no_done", ndone, 0);
        // reset in the middle of a scan, scan restarts from 0
        val_req = 1'b1; val_burst = 1'b1; val_bank = 2'd1;
        repeat (12) tick();
        do_reset(2);
        w = 0;
        while (!val_rvalid && w < RL + 6) begin tick(); w++; end
        chk("restart_raddr", val_raddr, 0);
        w = 0;
        while (!val_done && w < NW + RL + 6) begin tick(); w++; end
        chk("restart_done", val_done, 1'b1);
        val_req = 1'b0; val_burst = 1'b0;
        repeat (RL + 4) tick();
        // reset in the middle of a write cycle
        col_req = 1'b1; col_we = 1'b1; col_bank = 2'd1; col_addr = 5'd3; col_wdata = 64'hDEAD;
        w = 0;
        while (!col_gnt && w < 8) begin tick(); w++; end
        chk("rw_mem_we", mem_we, 3'b010);
        col_req = 1'b0; col_we = 1'b0;
        do_reset(1);
        vga_bank = 2'd1; vga_addr = 5'd3;
        repeat (RL + 6) tick();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) val_req = !val_req;
            if ($urandom_range(0, 5) == 0) col_req = !col_req;
            val_burst = $urandom_range(0, 15) == 0;
            val_we = 1'($urandom); col_we = 1'($urandom);
            val_bank = BW'($urandom_range(0, 3)); col_bank = BW'($urandom_range(0, 3));
            vga_bank = BW'($urandom_range(0, 3));
            val_addr = AW'($urandom); col_addr = AW'($urandom); vga_addr = AW'($urandom);
            val_wdata = {$urandom, $urandom}; col_wdata = {$urandom, $urandom};
            if ($urandom_range(0, 499) == 0) do_reset(1);
            tick();
        end
        val_req = 1'b0; col_req = 1'b0;
        repeat (RL + 4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
